// File: rtl/rw_control_logic_if.sv
// Host-side register bus of the 8259A command decoder: chip select, strobes,
// address bit and the buffered data byte.
interface rw_control_logic_if #(
   parameter int DATA_W = 8
);
   logic              cs_n;
   logic              rd_n;
   logic              wr_n;
   logic              a0;
   logic [DATA_W-1:0] data_in;

   modport master (output cs_n, rd_n, wr_n, a0, data_in);
   modport slave  (input  cs_n, rd_n, wr_n, a0, data_in);
endinterface

// File: rtl/rw_control_logic.sv
// 8259A write/read command decoder: captures host writes, runs the ICW1..ICW4
// initialization sequence and decodes OCW1/2/3 into strobes and register fields.
//
// state  | meaning
// UNINIT | after reset, only ICW1 accepted
// W_ICW2 | ICW1 seen, waiting for ICW2 (a0=1)
// W_ICW3 | cascade mode, waiting for ICW3 (a0=1)
// W_ICW4 | ic4 set, waiting for ICW4 (a0=1)
// READY  | init done, OCW1/2/3 decoded
module rw_control_logic #(
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   rw_control_logic_if.slave        bus,
   output logic                     icw1_stb,
   output logic                     icw2_stb,
   output logic                     icw3_stb,
   output logic                     icw4_stb,
   output logic                     ocw1_stb,
   output logic                     ocw2_stb,
   output logic                     ocw3_stb,
   output logic                     init_done,
   output logic                     ltim,
   output logic                     sngl,
   output logic [4:0]               vector_base,
   output logic [7:0]               cascade_cfg,
   output logic [4:0]               icw4_cfg,
   output logic [7:0]               imr,
   output logic [2:0]               ocw2_cmd,
   output logic [2:0]               ocw2_level,
   output logic                     poll_stb,
   output logic                     smm,
   output logic                     read_en,
   output logic [1:0]               read_sel
);

   typedef enum logic [2:0] {UNINIT, W_ICW2, W_ICW3, W_ICW4, READY} state_t;

   state_t            state;
   logic              wr_act;
   logic              lat_a0;
   logic [DATA_W-1:0] lat_d;
   logic              ic4;
   logic              read_isr;
   logic              wr_req;
   logic              is_icw1;

   assign wr_req   = ~bus.cs_n & ~bus.wr_n;
   assign is_icw1  = ~lat_a0 & lat_d[4];
   assign read_en  = ~bus.cs_n & ~bus.rd_n;
   assign read_sel = bus.a0 ? 2'b10 : {1'b0, read_isr};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= UNINIT;
         wr_act      <= 1'b0;
         lat_a0      <= 1'b0;
         lat_d       <= '0;
         ic4         <= 1'b0;
         read_isr    <= 1'b0;
         icw1_stb    <= 1'b0;
         icw2_stb    <= 1'b0;
         icw3_stb    <= 1'b0;
         icw4_stb    <= 1'b0;
         ocw1_stb    <= 1'b0;
         ocw2_stb    <= 1'b0;
         ocw3_stb    <= 1'b0;
         poll_stb    <= 1'b0;
         init_done   <= 1'b0;
         ltim        <= 1'b0;
         sngl        <= 1'b0;
         vector_base <= '0;
         cascade_cfg <= '0;
         icw4_cfg    <= '0;
         imr         <= '0;
         ocw2_cmd    <= '0;
         ocw2_level  <= '0;
         smm         <= 1'b0;
      end else begin
         icw1_stb <= 1'b0;
         icw2_stb <= 1'b0;
         icw3_stb <= 1'b0;
         icw4_stb <= 1'b0;
         ocw1_stb <= 1'b0;
         ocw2_stb <= 1'b0;
         ocw3_stb <= 1'b0;
         poll_stb <= 1'b0;

         // The write is held open while the strobe stays low; it commits on release.
         if (wr_req) begin
            wr_act <= 1'b1;
            lat_a0 <= bus.a0;
            lat_d  <= bus.data_in;
         end else if (wr_act) begin
            wr_act <= 1'b0;
            if (is_icw1) begin
               icw1_stb  <= 1'b1;
               ltim      <= lat_d[3];
               sngl      <= lat_d[1];
               ic4       <= lat_d[0];
               imr       <= '0;
               smm       <= 1'b0;
               read_isr  <= 1'b0;
               icw4_cfg  <= '0;
               init_done <= 1'b0;
               state     <= W_ICW2;
            end else begin
               case (state)
                  W_ICW2: if (lat_a0) begin
                     icw2_stb    <= 1'b1;
                     vector_base <= lat_d[7:3];
                     if (!sngl) begin
                        state <= W_ICW3;
                     end else if (ic4) begin
                        state <= W_ICW4;
                     end else begin
                        state     <= READY;
                        init_done <= 1'b1;
                     end
                  end
                  W_ICW3: if (lat_a0) begin
                     icw3_stb    <= 1'b1;
                     cascade_cfg <= lat_d[7:0];
                     if (ic4) begin
                        state <= W_ICW4;
                     end else begin
                        state     <= READY;
                        init_done <= 1'b1;
                     end
                  end
                  W_ICW4: if (lat_a0) begin
                     icw4_stb  <= 1'b1;
                     icw4_cfg  <= lat_d[4:0];
                     state     <= READY;
                     init_done <= 1'b1;
                  end
                  READY: begin
                     if (lat_a0) begin
                        ocw1_stb <= 1'b1;
                        imr      <= lat_d[7:0];
                     end else if (!lat_d[3]) begin
                        ocw2_stb   <= 1'b1;
                        ocw2_cmd   <= lat_d[7:5];
                        ocw2_level <= lat_d[2:0];
                     end else begin
                        ocw3_stb <= 1'b1;
                        poll_stb <= lat_d[2];
                        if (lat_d[1]) read_isr <= lat_d[0];
                        if (lat_d[6]) smm <= lat_d[5];
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule
